// File: rtl/rsa_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsa_loader_pkg
// Description : Shared types and helpers for the RSA operand loader.
//               FSM state encoding, operand channel indices and the
//               next-enabled-channel search used when walking the ch_en mask.
// Revision    : 1.0 - initial release
// ============================================================================
package rsa_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_FIN       = 3'd4
    } state_t;

    localparam int CH_R2  = 0;
    localparam int CH_N   = 1;
    localparam int CH_M   = 2;
    localparam int CH_PHI = 3;
    localparam int CH_EI  = 4;
    localparam int NUM_CH = 5;
    localparam int CH_W   = 3;

    // Lowest enabled channel index >= from. Returns NUM_CH when no enabled
    // channel remains, which the loader treats as "operand load complete".
    function automatic logic [CH_W-1:0] next_enabled_ch(
        input logic [NUM_CH-1:0] mask,
        input logic [CH_W-1:0]   from
    );
        logic [CH_W-1:0] ch;
        ch = CH_W'(NUM_CH);
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (CH_W'(i) >= from)) begin
                ch = CH_W'(i);
            end
        end
        return ch;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rsa_loader_rd_stage.sv
`default_nettype none
// ============================================================================
// Module      : rsa_loader_rd_stage
// Description : Result drain stage. Issues single-cycle reads of the CS
//               result FIFO, captures the returned word one cycle later and
//               presents it on a valid/ready stream (1 word per 2 cycles).
// Ports       : clk, rstn       - clock, synchronous active-low reset
//               i_active        - high while the loader is in DRAIN
//               i_data_cs       - CS FIFO data, valid the cycle after a read
//               i_m_ready       - downstream ready
//               o_rd_en         - CS FIFO read strobe
//               o_m_valid/data  - result stream
//               o_last_hs       - final result word handshakes this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_loader_rd_stage #(
    parameter int RES_WORDS = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_active,
    input  logic [31:0] i_data_cs,
    input  logic        i_m_ready,
    output logic        o_rd_en,
    output logic        o_m_valid,
    output logic [31:0] o_m_data,
    output logic        o_last_hs
);

    localparam int                c_RCNT_W    = $clog2(RES_WORDS + 1);
    localparam logic [c_RCNT_W-1:0] c_RES_WORDS = c_RCNT_W'(RES_WORDS);

    logic                r_pending;
    logic [c_RCNT_W-1:0] r_rcnt;
    logic                r_m_valid;
    logic [31:0]         r_m_data;
    logic                w_hs;
    logic                w_rd_en;

    assign w_hs = r_m_valid && i_m_ready;

    // A new read is only launched once the output register is free (or is
    // being emptied this cycle), so a captured word is never overwritten.
    assign w_rd_en = i_active && !r_pending && (!r_m_valid || i_m_ready)
                     && (r_rcnt < c_RES_WORDS);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pending <= 1'b0;
            r_rcnt    <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else if (!i_active) begin
            r_pending <= 1'b0;
            r_rcnt    <= '0;
            r_m_valid <= 1'b0;
        end else begin
            r_pending <= w_rd_en;
            if (r_pending) begin
                r_m_data  <= i_data_cs;
                r_m_valid <= 1'b1;
                r_rcnt    <= r_rcnt + 1'b1;
            end else if (w_hs) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign o_rd_en   = w_rd_en;
    assign o_m_valid = r_m_valid;
    assign o_m_data  = r_m_data;
    assign o_last_hs = i_active && w_hs && (r_rcnt == c_RES_WORDS);

endmodule
`default_nettype wire

// File: rtl/rsa_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : rsa_operand_loader
// Description : Host-side loader for the RSA modular wrapper. Streams operand
//               words into the R2/N/M/Phi/Ei FIFOs, waits for the wrapper's
//               done pulse, then drains the CS result FIFO onto a
//               valid/ready output stream.
// Ports       : clk, rstn            - clock, synchronous active-low reset
//               start, ch_en[4:0]    - job start pulse and channel mask
//               s_valid/ready/data/last - operand input stream
//               full[4:0]            - external FIFO full flags
//               wr_en[4:0], wr_data  - one-hot FIFO write strobes and data
//               done                 - wrapper completion pulse
//               rd_fifo_en, data_cs  - CS result FIFO read port
//               m_valid/ready/data   - result output stream
//               busy, err_len, err_tmo - status
// Options     : RSA_LOADER_TIMEOUT_EN - enables the WAIT_DONE watchdog
//               (TMO_CYCLES); otherwise err_tmo is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_operand_loader
    import rsa_loader_pkg::*;
#(
    parameter int          OP_WORDS   = 32,
    parameter int          RES_WORDS  = 32,
    parameter int unsigned TMO_CYCLES = 32'd1048576
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [4:0]  ch_en,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    input  logic [4:0]  full,
    output logic [4:0]  wr_en,
    output logic [31:0] wr_data,
    input  logic        done,
    output logic        rd_fifo_en,
    input  logic [31:0] data_cs,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        busy,
    output logic        err_len,
    output logic        err_tmo
);

    localparam int                  c_WCNT_W = (OP_WORDS > 1) ? $clog2(OP_WORDS) : 1;
    localparam logic [c_WCNT_W-1:0] c_WLAST  = c_WCNT_W'(OP_WORDS - 1);

    state_t              r_state;
    logic [NUM_CH-1:0]   r_mask;
    logic [CH_W-1:0]     r_ch;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic                r_done_seen;
    logic                r_busy;
    logic                r_err_len;

    logic                w_s_ready;
    logic                w_accept;
    logic                w_wlast;
    logic [CH_W-1:0]     w_next_ch;
    logic                w_drain;
    logic                w_last_hs;

    // Everything that can touch an external FIFO is qualified with rstn so a
    // reset cycle never issues a write or read, even before the state clears.
    assign w_s_ready = rstn && (r_state == ST_LOAD) && !full[r_ch];
    assign w_accept  = s_valid && w_s_ready;
    assign w_wlast   = (r_wcnt == c_WLAST);
    assign w_next_ch = next_enabled_ch(r_mask, r_ch + 1'b1);
    assign w_drain   = rstn && (r_state == ST_DRAIN);

    assign s_ready = w_s_ready;
    assign wr_en   = w_accept ? ({{(NUM_CH-1){1'b0}}, 1'b1} << r_ch) : '0;
    assign wr_data = w_accept ? s_data : '0;

`ifdef RSA_LOADER_TIMEOUT_EN
    logic [31:0] r_tmo_cnt;
    logic        r_err_tmo;
    logic        w_tmo_hit;

    assign w_tmo_hit = (r_tmo_cnt == 32'(TMO_CYCLES - 1));
    assign err_tmo   = r_err_tmo;
`else
    logic w_tmo_unused;

    assign w_tmo_unused = (TMO_CYCLES == 0);
    assign err_tmo      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_mask      <= '0;
            r_ch        <= '0;
            r_wcnt      <= '0;
            r_done_seen <= 1'b0;
            r_busy      <= 1'b0;
            r_err_len   <= 1'b0;
`ifdef RSA_LOADER_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_err_tmo   <= 1'b0;
`endif
        end else begin
            // done may arrive early (even mid-load); remember it until the
            // drain it triggers has completed.
            if ((r_state != ST_IDLE) && done) begin
                r_done_seen <= 1'b1;
            end
`ifdef RSA_LOADER_TIMEOUT_EN
            r_tmo_cnt <= (r_state == ST_WAIT_DONE) ? r_tmo_cnt + 32'd1 : '0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mask      <= ch_en;
                        r_ch        <= next_enabled_ch(ch_en, '0);
                        r_wcnt      <= '0;
                        r_err_len   <= 1'b0;
                        r_done_seen <= 1'b0;
                        r_busy      <= 1'b1;
`ifdef RSA_LOADER_TIMEOUT_EN
                        r_err_tmo   <= 1'b0;
`endif
                        r_state     <= (ch_en == '0) ? ST_WAIT_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        // The word count decides channel boundaries; s_last is
                        // only cross-checked against it.
                        if (s_last != w_wlast) begin
                            r_err_len <= 1'b1;
                        end
                        if (w_wlast) begin
                            r_wcnt <= '0;
                            r_ch   <= w_next_ch;
                            if (w_next_ch == CH_W'(NUM_CH)) begin
                                r_state <= ST_WAIT_DONE;
                            end
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (r_done_seen || done) begin
                        r_state <= ST_DRAIN;
                    end
`ifdef RSA_LOADER_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_err_tmo <= 1'b1;
                        r_state   <= ST_FIN;
                    end
`endif
                end
                ST_DRAIN: begin
                    if (w_last_hs) begin
                        r_done_seen <= 1'b0;
                        r_state     <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    rsa_loader_rd_stage #(
        .RES_WORDS (RES_WORDS)
    ) u_rd_stage (
        .clk       (clk),
        .rstn      (rstn),
        .i_active  (w_drain),
        .i_data_cs (data_cs),
        .i_m_ready (m_ready),
        .o_rd_en   (rd_fifo_en),
        .o_m_valid (m_valid),
        .o_m_data  (m_data),
        .o_last_hs (w_last_hs)
    );

    assign busy    = r_busy;
    assign err_len = r_err_len;

endmodule
`default_nettype wire
